// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one 8-bit memory data port.
// Latency: grant and write strobe 1 cycle after request; read data valid 2+RD_LAT cycles after request.
// Backpressure: one transaction in flight; a requester holds its level req until it sees its gnt pulse.
module mem_port_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic [7:0] a_rdata,
  output logic       a_rvalid,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic [7:0] b_rdata,
  output logic       b_rvalid,
  output logic [7:0] rw_addr,
  output logic [7:0] w,
  output logic       w_en,
  input  logic [7:0] r,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Counter reload: WAIT lasts RD_LAT cycles, the last one with cnt == 0.
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t     state;
  logic       last_b;  // 1 when B held the most recent grant
  logic       sel_b;   // owner of the transaction in flight
  logic       lat_we;  // direction of the transaction in flight
  logic [1:0] cnt;
  logic       pick_b;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    pick_b = b_req && (!a_req || !last_b);
  end

  // Single state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      sel_b    <= 1'b0;
      lat_we   <= 1'b0;
      cnt      <= 2'd0;
      rw_addr  <= 8'd0;
      w        <= 8'd0;
      w_en     <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= 8'd0;
      b_rdata  <= 8'd0;
      busy     <= 1'b0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      w_en     <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            // rw_addr/w double as the latched address and write data.
            sel_b   <= pick_b;
            lat_we  <= pick_b ? b_we    : a_we;
            rw_addr <= pick_b ? b_addr  : a_addr;
            w       <= pick_b ? b_wdata : a_wdata;
            w_en    <= pick_b ? b_we    : a_we;
            a_gnt   <= !pick_b;
            b_gnt   <= pick_b;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          last_b <= sel_b;
          if (lat_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            if (sel_b) begin
              b_rdata  <= r;
              b_rvalid <= 1'b1;
            end else begin
              a_rdata  <= r;
              a_rvalid <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
